// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture: pairs OV7670 RGB565 bytes into decimated RGB444 pixel strobes; defining OV7670_CAPTURE_DROP_COUNT_EN adds Dropped_Frames_o
module ov7670_pixel_capture #(
  parameter int H_ACTIVE_P    = 640,
  parameter int V_ACTIVE_P    = 480,
  parameter int DECIM_P       = 4,
  parameter int PIXEL_WIDTH_P = 12
) (
  input  logic                     Clk_i,
  input  logic                     Reset_i,
  input  logic                     Vsync_i,
  input  logic                     Href_i,
  input  logic [7:0]               Data_i,
  input  logic                     Buff_Locked_i,
  output logic [PIXEL_WIDTH_P-1:0] Pixel_Data_o,
  output logic                     Pixel_Available_o,
  output logic                     Frame_Start_o,
`ifdef OV7670_CAPTURE_DROP_COUNT_EN
  output logic [7:0]               Dropped_Frames_o,
`endif
  output logic                     Frame_Done_o
);
  localparam logic [1:0] WAIT_VSYNC = 2'd0, WAIT_START = 2'd1, CAPTURE = 2'd2;
  localparam logic [9:0] H_LIM = 10'(H_ACTIVE_P);
  localparam logic [8:0] V_LIM = 9'(V_ACTIVE_P);
  localparam logic [9:0] C_MASK = 10'(DECIM_P - 1);
  localparam logic [8:0] R_MASK = 9'(DECIM_P - 1);
  logic [1:0] state, state_n;
  logic vsync_d, href_d, phase;
  logic [6:0] hi_bits;
  logic [9:0] col_cnt;
  logic [8:0] row_cnt;
  logic cap, vs_fall, vs_rise, href_fall, start, low_byte, keep;
  always_comb begin
    cap = state == CAPTURE;
    vs_fall = vsync_d & ~Vsync_i;
    vs_rise = ~vsync_d & Vsync_i;
    href_fall = href_d & ~Href_i;
    start = state == WAIT_START && vs_fall && !Buff_Locked_i;
    low_byte = cap & Href_i & phase;
    keep = low_byte && col_cnt < H_LIM && row_cnt < V_LIM && (col_cnt & C_MASK) == '0 && (row_cnt & R_MASK) == '0;
    state_n = state == WAIT_VSYNC ? (Vsync_i ? WAIT_START : WAIT_VSYNC) :
              state == WAIT_START ? (start ? CAPTURE : WAIT_START) :
              cap ? (vs_rise ? WAIT_START : CAPTURE) : WAIT_VSYNC;
  end
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state <= WAIT_VSYNC;
      vsync_d <= 1'b0;
      href_d <= 1'b0;
      phase <= 1'b0;
      hi_bits <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      Pixel_Data_o <= '0;
      Pixel_Available_o <= 1'b0;
      Frame_Start_o <= 1'b0;
      Frame_Done_o <= 1'b0;
    end else begin
      state <= state_n;
      vsync_d <= Vsync_i;
      href_d <= Href_i;
      phase <= cap & Href_i & ~phase;
      if (cap & Href_i & ~phase) hi_bits <= {Data_i[7:4], Data_i[2:0]};
      // counters saturate at the active size so oversized lines/frames never wrap into kept positions
      if (start) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (cap & href_fall) begin
        col_cnt <= '0;
        if (row_cnt < V_LIM) row_cnt <= row_cnt + 9'd1;
      end else if (low_byte && col_cnt < H_LIM) col_cnt <= col_cnt + 10'd1;
      if (keep) Pixel_Data_o <= PIXEL_WIDTH_P'({hi_bits, Data_i[7], Data_i[4:1]});
      Pixel_Available_o <= keep;
      Frame_Start_o <= start;
      Frame_Done_o <= cap & vs_rise;
    end
  end
`ifdef OV7670_CAPTURE_DROP_COUNT_EN
  always_ff @(posedge Clk_i) begin
    if (Reset_i) Dropped_Frames_o <= '0;
    else if (state == WAIT_START && vs_fall && Buff_Locked_i && Dropped_Frames_o != 8'hFF)
      Dropped_Frames_o <= Dropped_Frames_o + 8'd1;
  end
`endif
endmodule
